hu_dma_copy_engine: RTL

HU_DMA_COPY_ENGINE -- requirements
Module: hu_dma_copy_engine

---
 rtl/hu_dma_copy_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hu_dma_copy_engine.sv
// DMA copy engine: chunked read requests feed a small FIFO that drains to matching write requests,
// with optional per-beat byte reversal. One start per conf_done rising edge; acc_done pulses at the end.
module hu_dma_copy_engine #(
    parameter int DMA_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          conf_info_src_offset,
    input  logic [31:0]          conf_info_dst_offset,
    input  logic [31:0]          conf_info_len,
    input  logic [31:0]          conf_info_mode,
    input  logic                 conf_done,
    output logic                 acc_done,
    output logic [31:0]          debug,
    output logic                 dma_read_ctrl_valid,
    input  logic                 dma_read_ctrl_ready,
    output logic [31:0]          dma_read_ctrl_data_index,
    output logic [31:0]          dma_read_ctrl_data_length,
    output logic [2:0]           dma_read_ctrl_data_size,
    input  logic                 dma_read_chnl_valid,
    output logic                 dma_read_chnl_ready,
    input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
    output logic                 dma_write_ctrl_valid,
    input  logic                 dma_write_ctrl_ready,
    output logic [31:0]          dma_write_ctrl_data_index,
    output logic [31:0]          dma_write_ctrl_data_length,
    output logic [2:0]           dma_write_ctrl_data_size,
    output logic                 dma_write_chnl_valid,
    input  logic                 dma_write_chnl_ready,
    output logic [DMA_WIDTH-1:0] dma_write_chnl_data
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          NBYTES  = DMA_WIDTH / 8;
    localparam logic [31:0] BURST   = 32'(MAX_BURST);
    localparam logic [2:0]  SIZE    = (DMA_WIDTH == 64) ? 3'b011 : 3'b010;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_REQ = 4'd1,
        WR_REQ = 4'd2,
        XFER   = 4'd3,
        DONE   = 4'd4
    } state_t;

    state_t               r_state;
    logic                 r_conf_done;
    logic                 r_acc_done;
    logic                 r_rev;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_remain;
    logic [31:0]          r_issued;
    logic [31:0]          r_clen;
    logic [31:0]          r_rd_cnt;
    logic [31:0]          r_wr_cnt;
    logic [27:0]          r_chunks;
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [DMA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic                 w_start;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_rd_rdy;
    logic                 w_wr_vld;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    logic [31:0]          w_left;
    logic [DMA_WIDTH-1:0] w_head;
    logic [DMA_WIDTH-1:0] w_rev;

    function automatic logic [31:0] f_clen(input logic [31:0] rem);
        return (rem < BURST) ? rem : BURST;
    endfunction

    assign w_start  = conf_done && !r_conf_done && (r_state == IDLE);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_rd_rdy = (r_state == XFER) && !w_full && (r_rd_cnt < r_clen);
    assign w_wr_vld = (r_state == XFER) && !w_empty && (r_wr_cnt < r_clen);
    assign w_push   = w_rd_rdy && dma_read_chnl_valid;
    assign w_pop    = w_wr_vld && dma_write_chnl_ready;
    assign w_last   = w_pop && (r_wr_cnt == r_clen - 32'd1);
    assign w_left   = r_remain - r_clen;
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < NBYTES; i++)
            w_rev[8*i +: 8] = w_head[DMA_WIDTH-8-8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= dma_read_chnl_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_conf_done <= 1'b0;
            r_acc_done  <= 1'b0;
            r_rev       <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_remain    <= '0;
            r_issued    <= '0;
            r_clen      <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_chunks    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_conf_done <= conf_done;
            r_acc_done  <= (r_state == DONE);
            if (w_push) begin
                r_wptr   <= r_wptr + PTR_ONE;
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + PTR_ONE;
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            case (r_state)
                IDLE: if (w_start) begin
                    r_src    <= conf_info_src_offset;
                    r_dst    <= conf_info_dst_offset;
                    r_rev    <= conf_info_mode[0];
                    r_remain <= conf_info_len;
                    r_clen   <= f_clen(conf_info_len);
                    r_issued <= '0;
                    r_chunks <= '0;
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                    r_state  <= (conf_info_len == 32'd0) ? DONE : RD_REQ;
                end
                RD_REQ: if (dma_read_ctrl_ready) r_state <= WR_REQ;
                WR_REQ: if (dma_write_ctrl_ready) r_state <= XFER;
                XFER: if (w_last) begin
                    // All reads of the chunk have landed by now, so clearing both counters is safe.
                    r_remain <= w_left;
                    r_issued <= r_issued + r_clen;
                    r_clen   <= f_clen(w_left);
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                    if (r_chunks != '1) r_chunks <= r_chunks + 28'd1;
                    r_state  <= (w_left != 32'd0) ? RD_REQ : DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign acc_done                   = !rst && r_acc_done;
    assign debug                      = rst ? 32'd0 : {4'(r_state), r_chunks};
    assign dma_read_ctrl_valid        = !rst && (r_state == RD_REQ);
    assign dma_read_ctrl_data_index   = rst ? 32'd0 : r_src + r_issued;
    assign dma_read_ctrl_data_length  = rst ? 32'd0 : r_clen;
    assign dma_read_ctrl_data_size    = rst ? 3'd0 : SIZE;
    assign dma_read_chnl_ready        = !rst && w_rd_rdy;
    assign dma_write_ctrl_valid       = !rst && (r_state == WR_REQ);
    assign dma_write_ctrl_data_index  = rst ? 32'd0 : r_dst + r_issued;
    assign dma_write_ctrl_data_length = rst ? 32'd0 : r_clen;
    assign dma_write_ctrl_data_size   = rst ? 3'd0 : SIZE;
    assign dma_write_chnl_valid       = !rst && w_wr_vld;
    assign dma_write_chnl_data        = rst ? '0 : (r_rev ? w_rev : w_head);

endmodule
